// File: rtl/rob_commit.sv
// 8-entry reorder buffer: in-order allocate, out-of-order complete, in-order retire,
// with youngest-first rollback walk on mispredict. Optional trace storage: ROB_TRACE_EN.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int PREG_W = 7,
    parameter int AREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [AREG_W-1:0] disp_areg,
    input  logic [PREG_W-1:0] disp_pd_new,
    input  logic [PREG_W-1:0] disp_pd_old,
    input  logic              disp_has_rd,
    input  logic              disp_is_store,
`ifdef ROB_TRACE_EN
    input  logic [31:0]       disp_pc,
`endif
    output logic [IDX_W-1:0]  disp_rob_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_rob_idx,
    input  logic [PREG_W-1:0] wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              mispredict,
    input  logic [IDX_W-1:0]  mis_rob_idx,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_areg,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_free,
    output logic              commit_has_rd,
    output logic              commit_store,
`ifdef ROB_TRACE_EN
    output logic [31:0]       commit_pc,
    output logic [31:0]       commit_data,
`endif
    output logic              rb_valid,
    output logic [AREG_W-1:0] rb_areg,
    output logic [PREG_W-1:0] rb_pd_old,
    output logic [PREG_W-1:0] rb_pd_free,
    output logic              rb_has_rd,
    output logic              rob_empty,
    output logic              dbg_state
);
    // Handshakes: dispatch transfers on a clk edge where disp_valid && disp_ready;
    // commit and rollback outputs are single-cycle strobes with no back-pressure.
    typedef enum logic {IDLE = 1'b0, ROLLBACK = 1'b1} state_t;

    localparam logic [IDX_W-1:0] ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(DEPTH);

    state_t state, state_nxt;
    logic [IDX_W-1:0]  head, tail, walk, stop, stop_nxt, mis_k, k_eff;
    logic [IDX_W:0]    count, count_nxt;
    logic [DEPTH-1:0]  valid, done, valid_nxt, done_nxt, squash, has_rd_q, is_store_q;
    logic [AREG_W-1:0] areg_q   [DEPTH];
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic disp_fire, commit_fire, mis_take, wb_ok;
    logic unused_wb;

    assign commit_fire = valid[head] && done[head];
    assign disp_ready  = (count != FULL) && (state == IDLE) && !mispredict;
    assign disp_fire   = disp_valid && disp_ready;
    assign mis_k       = tail - mis_rob_idx - ONE;

    // During a walk only branches older than the current stop point can shrink the ROB further.
    always_comb begin
        mis_take = 1'b0;
        if (mispredict) begin
            if (state == IDLE) mis_take = 1'b1;
            else               mis_take = (mis_rob_idx - head) < (stop - head);
        end
        k_eff    = mis_take ? mis_k : '0;
        stop_nxt = mis_take ? mis_rob_idx : stop;
        squash   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mis_take && ((IDX_W'(i) - mis_rob_idx - ONE) < mis_k)) squash[i] = 1'b1;
        end
    end

    assign wb_ok = wb_valid && valid[wb_rob_idx] && !squash[wb_rob_idx];

    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        if (commit_fire) valid_nxt[head] = 1'b0;
        valid_nxt = valid_nxt & ~squash;
        if (wb_ok) done_nxt[wb_rob_idx] = 1'b1;
        if (disp_fire) begin
            valid_nxt[tail] = 1'b1;
            done_nxt[tail]  = 1'b0;
        end
        count_nxt = count - {1'b0, k_eff};
        if (disp_fire)   count_nxt = count_nxt + (IDX_W+1)'(1);
        if (commit_fire) count_nxt = count_nxt - (IDX_W+1)'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mis_take && (mis_k != '0)) state_nxt = ROLLBACK;
            ROLLBACK: if (walk == stop_nxt + ONE)    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            walk  <= '0;
            stop  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            valid <= valid_nxt;
            done  <= done_nxt;
            count <= count_nxt;
            stop  <= stop_nxt;
            if (commit_fire) head <= head + ONE;
            if (mis_take)       tail <= mis_rob_idx + ONE;
            else if (disp_fire) tail <= tail + ONE;
            if (state == ROLLBACK) walk <= walk - ONE;
            else if (mis_take)     walk <= tail - ONE;
        end
    end

    // Entry snapshot fields are only rewritten at dispatch, so the walk can read them safely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_rd_q   <= '0;
            is_store_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                areg_q[i]   <= '0;
                pd_new_q[i] <= '0;
                pd_old_q[i] <= '0;
            end
        end else if (disp_fire) begin
            has_rd_q[tail]   <= disp_has_rd;
            is_store_q[tail] <= disp_is_store;
            areg_q[tail]     <= disp_areg;
            pd_new_q[tail]   <= disp_pd_new;
            pd_old_q[tail]   <= disp_pd_old;
        end
    end

`ifdef ROB_TRACE_EN
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (disp_fire) pc_q[tail] <= disp_pc;
            if (wb_ok)     data_q[wb_rob_idx] <= wb_data;
        end
    end

    assign commit_pc   = commit_fire ? pc_q[head]   : '0;
    assign commit_data = commit_fire ? data_q[head] : '0;
    assign unused_wb   = ^wb_rd;
`else
    assign unused_wb   = ^{wb_rd, wb_data};
`endif

    assign commit_valid   = commit_fire;
    assign commit_areg    = commit_fire ? areg_q[head]   : '0;
    assign commit_pd_new  = commit_fire ? pd_new_q[head] : '0;
    assign commit_pd_free = commit_fire ? pd_old_q[head] : '0;
    assign commit_has_rd  = commit_fire && has_rd_q[head];
    assign commit_store   = commit_fire && is_store_q[head];

    assign rb_valid   = (state == ROLLBACK);
    assign rb_areg    = rb_valid ? areg_q[walk]   : '0;
    assign rb_pd_old  = rb_valid ? pd_old_q[walk] : '0;
    assign rb_pd_free = rb_valid ? pd_new_q[walk] : '0;
    assign rb_has_rd  = rb_valid && has_rd_q[walk];

    assign disp_rob_idx = tail;
    assign rob_empty    = (count == '0);
    assign dbg_state    = (state == ROLLBACK);
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a behavioural ROB model with commit and rollback
// scoreboard queues, checked every cycle on the falling clock edge.
module tb_rob_commit;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int PREG_W = 7;
  localparam int AREG_W = 5;
  localparam int RW     = AREG_W + 2 * PREG_W + 2;

  logic clk = 1'b0;
  logic rst;
  logic disp_valid, disp_ready, disp_has_rd, disp_is_store;
  logic [AREG_W-1:0] disp_areg;
  logic [PREG_W-1:0] disp_pd_new, disp_pd_old;
  logic [IDX_W-1:0] disp_rob_idx, wb_rob_idx, mis_rob_idx;
  logic wb_valid, mispredict;
  logic [PREG_W-1:0] wb_rd;
  logic [31:0] wb_data;
  logic commit_valid, commit_has_rd, commit_store;
  logic [AREG_W-1:0] commit_areg, rb_areg;
  logic [PREG_W-1:0] commit_pd_new, commit_pd_free, rb_pd_old, rb_pd_free;
  logic rb_valid, rb_has_rd, rob_empty, dbg_state;
`ifdef ROB_TRACE_EN
  logic [31:0] disp_pc, commit_pc, commit_data;
`endif

  rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_areg(disp_areg),
    .disp_pd_new(disp_pd_new), .disp_pd_old(disp_pd_old), .disp_has_rd(disp_has_rd),
    .disp_is_store(disp_is_store),
`ifdef ROB_TRACE_EN
    .disp_pc(disp_pc),
`endif
    .disp_rob_idx(disp_rob_idx),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_rd(wb_rd), .wb_data(wb_data),
    .mispredict(mispredict), .mis_rob_idx(mis_rob_idx),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_pd_new(commit_pd_new),
    .commit_pd_free(commit_pd_free), .commit_has_rd(commit_has_rd), .commit_store(commit_store),
`ifdef ROB_TRACE_EN
    .commit_pc(commit_pc), .commit_data(commit_data),
`endif
    .rb_valid(rb_valid), .rb_areg(rb_areg), .rb_pd_old(rb_pd_old), .rb_pd_free(rb_pd_free),
    .rb_has_rd(rb_has_rd), .rob_empty(rob_empty), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // scoreboard: record = {areg, pd_new, pd_old, has_rd, is_store}
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] rb_q[$];
  logic [RW-1:0] rec [DEPTH];
  logic [DEPTH-1:0] m_valid, m_done;
  int m_head, m_tail, m_count, m_stop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_done  = '0;
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    m_stop  = 0;
    exp_q.delete();
    rb_q.delete();
  endtask

  // driver tasks
  task automatic clear_in();
    disp_valid = 1'b0; disp_areg = '0; disp_pd_new = '0; disp_pd_old = '0;
    disp_has_rd = 1'b0; disp_is_store = 1'b0;
    wb_valid = 1'b0; wb_rob_idx = '0; wb_rd = '0; wb_data = '0;
    mispredict = 1'b0; mis_rob_idx = '0;
`ifdef ROB_TRACE_EN
    disp_pc = '0;
`endif
  endtask

  task automatic set_disp();
    disp_valid    = 1'b1;
    disp_areg     = AREG_W'($urandom_range(0, 31));
    disp_pd_new   = PREG_W'($urandom_range(0, 127));
    disp_pd_old   = PREG_W'($urandom_range(0, 127));
    disp_has_rd   = 1'($urandom_range(0, 1));
    disp_is_store = 1'($urandom_range(0, 1));
  endtask

  task automatic set_wb(input int idx);
    wb_valid   = 1'b1;
    wb_rob_idx = IDX_W'(idx);
    wb_rd      = PREG_W'($urandom_range(0, 127));
    wb_data    = $urandom;
  endtask

  task automatic set_mis(input int idx);
    mispredict  = 1'b1;
    mis_rob_idx = IDX_W'(idx);
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic [RW-1:0] e;
    logic rb_state, exp_cv, exp_ready;
    int k, mis, idx, age_m, age_s;
    @(negedge clk);
    rb_state  = (rb_q.size() != 0);
    exp_cv    = m_valid[m_head] && m_done[m_head];
    exp_ready = (m_count != DEPTH) && !rb_state && !mispredict;
    check("commit_valid", 32'(commit_valid), 32'(exp_cv));
    check("rb_valid", 32'(rb_valid), 32'(rb_state));
    check("dbg_state", 32'(dbg_state), 32'(rb_state));
    check("disp_ready", 32'(disp_ready), 32'(exp_ready));
    check("rob_empty", 32'(rob_empty), 32'(m_count == 0));
    check("disp_rob_idx", 32'(disp_rob_idx), m_tail);
    if (exp_cv) begin
      e = exp_q.pop_front();
      check("commit_rec", 32'({commit_areg, commit_pd_new, commit_pd_free, commit_has_rd, commit_store}), 32'(e));
    end
    if (rb_state) begin
      e = rb_q.pop_front();
      check("rb_rec", 32'({rb_areg, rb_pd_old, rb_pd_free, rb_has_rd}),
            32'({e[RW-1 -: AREG_W], e[2 +: PREG_W], e[2+PREG_W +: PREG_W], e[1]}));
    end
    if (mispredict) begin
      mis   = int'(mis_rob_idx);
      age_m = (mis - m_head) & (DEPTH - 1);
      age_s = (m_stop - m_head) & (DEPTH - 1);
      if (!rb_state || age_m < age_s) begin
        k = (m_tail - mis - 1) & (DEPTH - 1);
        for (int j = 0; j < k; j++) begin
          idx = (m_tail - 1 - j) & (DEPTH - 1);
          m_valid[idx] = 1'b0;
          rb_q.push_back(rec[idx]);
          e = exp_q.pop_back();
        end
        m_tail  = (mis + 1) & (DEPTH - 1);
        m_count = m_count - k;
        m_stop  = mis;
      end
    end
    if (wb_valid && m_valid[wb_rob_idx]) m_done[wb_rob_idx] = 1'b1;
    if (exp_cv) begin
      m_valid[m_head] = 1'b0;
      m_head  = (m_head + 1) & (DEPTH - 1);
      m_count = m_count - 1;
    end
    if (disp_valid && exp_ready) begin
      rec[m_tail] = {disp_areg, disp_pd_new, disp_pd_old, disp_has_rd, disp_is_store};
      m_valid[m_tail] = 1'b1;
      m_done[m_tail]  = 1'b0;
      exp_q.push_back(rec[m_tail]);
      m_tail  = (m_tail + 1) & (DEPTH - 1);
      m_count = m_count + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    #2;
    check("rst_rb_valid", 32'(rb_valid), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_rob_empty", 32'(rob_empty), 32'd1);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_disp_rob_idx", 32'(disp_rob_idx), 32'd0);
    check("rst_commit_fields", 32'({commit_areg, commit_pd_new, commit_pd_free, commit_has_rd, commit_store}), 32'd0);
    check("rst_rb_fields", 32'({rb_areg, rb_pd_old, rb_pd_free, rb_has_rd}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // directed sequence
  initial begin
    clear_in();
    do_reset();

    // fill all eight entries, then one rejected attempt
    for (int i = 0; i < 8; i++) begin
      set_disp();
      cycle();
    end
    set_disp();
    cycle();
    clear_in();
    check("t1_full_ready", 32'(disp_ready), 32'd0);
    check("t1_not_empty", 32'(rob_empty), 32'd0);

    // out-of-order writeback 2, 0, 1 -> in-order commits 0, 1, 2
    set_wb(2); cycle(); clear_in();
    check("t2_no_commit_yet", 32'(commit_valid), 32'd0);
    set_wb(0); cycle(); clear_in();
    check("t2_commit0", 32'(commit_valid), 32'd1);
    check("t2_free0", 32'(commit_pd_free), 32'(rec[0][2 +: PREG_W]));
    set_wb(1); cycle(); clear_in();
    idle(2);
    check("t2_head3_stall", 32'(commit_valid), 32'd0);

    // refill to full, then dispatch held while the head commits
    for (int i = 0; i < 3; i++) begin
      set_disp();
      cycle();
    end
    clear_in();
    set_wb(3); cycle(); clear_in();
    set_disp();
    cycle();
    check("t3_ready_after_commit", 32'(disp_ready), 32'd1);
    cycle();
    clear_in();
    check("t3_full_again", 32'(disp_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_wb(i); cycle(); clear_in();
    end
    idle(10);
    check("t3_drained", 32'(rob_empty), 32'd1);

    // mispredict at 2 with 0..5 live; same-cycle dispatch and writeback to a squashed entry
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_disp();
      cycle();
    end
    clear_in();
    set_mis(2); set_disp(); set_wb(5); cycle(); clear_in();
    check("t4_rb_start", 32'(rb_valid), 32'd1);
    set_wb(4); cycle(); clear_in();
    idle(2);
    check("t4_rb_done", 32'(rb_valid), 32'd0);
    check("t4_tail", 32'(disp_rob_idx), 32'd3);
    set_mis(2); cycle(); clear_in();
    check("t4_k0_no_rb", 32'(rb_valid), 32'd0);
    check("t4_k0_tail", 32'(disp_rob_idx), 32'd3);
    set_wb(0); cycle(); set_wb(1); cycle(); set_wb(2); cycle(); set_wb(4); cycle(); clear_in();
    idle(4);
    check("t4_drained", 32'(rob_empty), 32'd1);

    // wrapped rollback from 5, nested older mispredict at 3, younger one ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_disp();
      cycle();
    end
    clear_in();
    set_mis(5); cycle(); clear_in();
    cycle();
    set_mis(3); cycle(); clear_in();
    set_mis(6); cycle(); clear_in();
    cycle();
    check("t5_rb_done", 32'(rb_valid), 32'd0);
    check("t5_tail", 32'(disp_rob_idx), 32'd4);
    idle(1);

    // reset in the middle of a rollback walk
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_disp();
      cycle();
    end
    clear_in();
    set_mis(0); cycle(); clear_in();
    cycle();
    do_reset();
    check("t6_first_idx", 32'(disp_rob_idx), 32'd0);
    set_disp(); cycle(); clear_in();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
